// File: rtl/main_decode_pkg.sv
// Shared opcode/funct encodings, ctrl bit positions and latency defaults
// for the main decode pipeline.
package main_decode_pkg;

    localparam int MUL_CYCLES_DEF = 3;
    localparam int DIV_CYCLES_DEF = 32;

    localparam int CTRL_W = 9;

    // ctrl = {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, hilo_we[1:0]}
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_HILO_HI  = 1;
    localparam int CTRL_HILO_LO  = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Counter only has to hold latency-1; a 1-cycle setting still needs one bit.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int m;
        m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/main_decode_if.sv
// Instruction-in / control-bundle-out handshake bus of the decode pipeline,
// plus the mult/div sequencing strobes.
interface main_decode_if;
    import main_decode_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
    logic              md_start;
    logic [1:0]        md_op;
    logic              md_busy;
    logic              md_done;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, ctrl, illegal, md_start, md_op, md_busy, md_done
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, ctrl, illegal, md_start, md_op, md_busy, md_done
    );

endinterface

// File: rtl/main_decode_comb.sv
// Combinational op/funct to ctrl decode. Mult/div functs are legal only when
// MAIN_DECODE_MULDIV_EN is defined.
module main_decode_comb
    import main_decode_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic              is_md,
    output logic [1:0]        md_op
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[25:6];

    // NOTE: every output gets a default first so no path through the cases infers a latch.
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        is_md   = 1'b0;
        md_op   = 2'b00;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO: begin
                        ctrl[CTRL_REGWRITE] = 1'b1;
                        ctrl[CTRL_REGDST]   = 1'b1;
                    end
                    FN_MTHI: ctrl[CTRL_HILO_HI] = 1'b1;
                    FN_MTLO: ctrl[CTRL_HILO_LO] = 1'b1;
`ifdef MAIN_DECODE_MULDIV_EN
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        is_md = 1'b1;
                        md_op = funct[1:0];
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_MEMTOREG] = 1'b1;
            end
            OP_SW: begin
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[CTRL_MEMWRITE] = 1'b1;
            end
            OP_BEQ: ctrl[CTRL_BRANCH] = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
            end
            OP_J:    ctrl[CTRL_JUMP] = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/main_decode_pipe.sv
// One-stage registered instruction decoder with valid/ready handshake and an
// optional mult/div issue sequencer enabled by MAIN_DECODE_MULDIV_EN.
module main_decode_pipe
    import main_decode_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
)
(
    input  logic          clk,
    input  logic          rst_n,
    main_decode_if.slave  bus
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              dec_is_md;
    logic [1:0]        dec_md_op;

    logic              idle;
    logic              accept;
    logic              out_valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              illegal_q;

    main_decode_comb u_comb (
        .instr   (bus.instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .is_md   (dec_is_md),
        .md_op   (dec_md_op)
    );

    // Flush blocks acceptance so a flushed cycle never loads a new bundle.
    assign bus.in_ready  = idle & ~bus.flush & (~out_valid_q | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.ctrl      = ctrl_q;
    assign bus.illegal   = illegal_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ctrl_q      <= dec_ctrl;
            illegal_q   <= dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef MAIN_DECODE_MULDIV_EN
    localparam int              CNT_W    = cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_start_q, md_start_d;
    logic [1:0]       md_op_q, md_op_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
            md_op_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
            md_op_q    <= md_op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_start_d = 1'b0;
        md_op_d    = md_op_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && dec_is_md) begin
                    state_d    = ST_BUSY;
                    md_start_d = 1'b1;
                    md_op_d    = dec_md_op;
                    // DIV/DIVU carry op bit 1; MULT/MULTU do not.
                    cnt_d      = dec_md_op[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign idle         = (state_q == ST_IDLE);
    assign bus.md_busy  = (state_q == ST_BUSY);
    assign bus.md_done  = (state_q == ST_BUSY) && (cnt_q == '0);
    assign bus.md_start = md_start_q;
    assign bus.md_op    = md_op_q;
`else
    localparam int unused_cycles = MUL_CYCLES + DIV_CYCLES;
    logic unused_md;

    assign unused_md    = ^{dec_is_md, dec_md_op};
    assign idle         = 1'b1;
    assign bus.md_busy  = 1'b0;
    assign bus.md_done  = 1'b0;
    assign bus.md_start = 1'b0;
    assign bus.md_op    = 2'b00;
`endif

endmodule

// File: tb/tb_main_decode_pipe.sv
// Scoreboard bench for main_decode_pipe: directed corner cases followed by
// randomized traffic checked against a behavioural decode/latency model.
module tb_main_decode_pipe;

    localparam int MUL_N = 3;
    localparam int DIV_N = 32;
`ifdef MAIN_DECODE_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    localparam logic [5:0] IOPS [10] = '{6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c,
                                         6'h0d, 6'h0e, 6'h0f, 6'h02, 6'h23};
    localparam logic [5:0] RFNS [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                         6'h26, 6'h27, 6'h2a, 6'h2b};

    typedef struct packed {
        logic [8:0] ctrl;
        logic       illegal;
        logic       md;
        logic [1:0] md_op;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    main_decode_if bus ();

    main_decode_pipe #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   busy_rem   = 0;
    bit   start_pend = 1'b0;
    logic [1:0] exp_md_op = 2'b00;
    bit   armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode straight from the instruction-class table.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        e  = '0;
        case (op)
            6'h00: begin
                if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                               [6'h20:6'h27], 6'h2a, 6'h2b})
                    e.ctrl = {7'b1100000, 2'b00};
                else if (fn == 6'h11) e.ctrl = {7'b0000000, 2'b10};
                else if (fn == 6'h13) e.ctrl = {7'b0000000, 2'b01};
                else if (fn inside {[6'h18:6'h1b]} && MULDIV) begin
                    e.md = 1'b1;
                    case (fn)
                        6'h18:   e.md_op = 2'b00;
                        6'h19:   e.md_op = 2'b01;
                        6'h1a:   e.md_op = 2'b10;
                        default: e.md_op = 2'b11;
                    endcase
                end else e.illegal = 1'b1;
            end
            6'h23:                      e.ctrl = {7'b1010010, 2'b00};
            6'h2b:                      e.ctrl = {7'b0010100, 2'b00};
            6'h04:                      e.ctrl = {7'b0001000, 2'b00};
            6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0f: e.ctrl = {7'b1010000, 2'b00};
            6'h02:                      e.ctrl = {7'b0000001, 2'b00};
            default:                    e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 9))
            0, 1, 2, 3: r[31:26] = IOPS[$urandom_range(0, 9)];
            4, 5: begin r[31:26] = 6'h00; r[5:0] = RFNS[$urandom_range(0, 15)]; end
            6:    r[31:26] = 6'h00;
            7:    ;
            8: begin r[31:26] = 6'h00; r[5:0] = 6'h10 + 6'($urandom_range(0, 3)); end
            default: begin
                if ($urandom_range(0, 2) == 0) begin
                    r[31:26] = 6'h00;
                    r[5:0]   = 6'h18 + 6'($urandom_range(0, 3));
                end else r[31:26] = IOPS[$urandom_range(0, 9)];
            end
        endcase
        return r;
    endfunction

    // Monitor / scoreboard: compares at every falling edge, then advances the model.
    always @(negedge clk) begin : monitor
        logic exp_iready;
        exp_t e;
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            busy_rem   = 0;
            start_pend = 1'b0;
            armed      = 1'b1;
        end else if (armed) begin
            exp_iready = (busy_rem == 0) && !bus.flush && (exp_q.size() == 0 || bus.out_ready);
            check("in_ready", bus.in_ready, exp_iready);
            check("out_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("ctrl", bus.ctrl, e.ctrl);
                check("illegal", bus.illegal, e.illegal);
                if (bus.flush || bus.out_ready) void'(exp_q.pop_front());
            end
            check("md_start", bus.md_start, start_pend);
            check("md_busy", bus.md_busy, busy_rem > 0);
            check("md_done", bus.md_done, busy_rem == 1);
            if (start_pend) check("md_op", bus.md_op, exp_md_op);
            start_pend = 1'b0;
            if (busy_rem > 0) busy_rem--;
            if (bus.in_valid && exp_iready) begin
                e = ref_decode(bus.instr);
                exp_q.push_back(e);
                if (e.md) begin
                    busy_rem   = e.md_op[1] ? DIV_N : MUL_N;
                    start_pend = 1'b1;
                    exp_md_op  = e.md_op;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        while ((bus.md_busy || bus.out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("quiet_timeout", n < 100, 1);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_ctrl"}, bus.ctrl, 0);
        check({tag, "_illegal"}, bus.illegal, 0);
        check({tag, "_md_start"}, bus.md_start, 0);
        check({tag, "_md_busy"}, bus.md_busy, 0);
        check({tag, "_md_done"}, bus.md_done, 0);
        check({tag, "_md_op"}, bus.md_op, 0);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int nb;
        int nd;
        int done_at;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        check_reset_state("rst");

        // LW with consumer ready
        drive(1'b1, 32'h8C220004, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("lw_valid", bus.out_valid, 1);
        check("lw_ctrl", bus.ctrl, 9'b101001000);
        check("lw_illegal", bus.illegal, 0);
        tick();

        // MTHI held under back-pressure
        drive(1'b1, {6'h00, 20'h12345, 6'h11}, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("mthi_hold_ctrl", bus.ctrl, 9'b000000010);
            check("mthi_hold_in_ready", bus.in_ready, 0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // Undefined opcode
        drive(1'b1, {6'h3f, 26'h1234567}, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("op3f_valid", bus.out_valid, 1);
        check("op3f_ctrl", bus.ctrl, 0);
        check("op3f_illegal", bus.illegal, 1);
        tick();

        // MULTU: legal issue with the mult/div unit, illegal without it
        drive(1'b1, {6'h00, 20'h0, 6'h19}, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("multu_illegal", bus.illegal, MULDIV ? 0 : 1);
        check("multu_md_start", bus.md_start, MULDIV ? 1 : 0);
        tick();
        wait_quiet();

        // Flush beats a simultaneous offer and consume
        drive(1'b1, {6'h08, 26'h0}, 1'b0, 1'b0);
        tick();
        drive(1'b1, {6'h0d, 26'h0}, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_illegal", bus.illegal, 0);
        tick();

        // Flush during MULT busy does not abort it
        wait_quiet();
        drive(1'b1, {6'h00, 20'h0, 6'h18}, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.md_done) nd++;
        end
        tick();
        check("mult_flush_done_count", nd, MULDIV ? 1 : 0);

        // Full DIV latency profile
        wait_quiet();
        drive(1'b1, {6'h00, 20'h0, 6'h1a}, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        nb = 0;
        nd = 0;
        done_at = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.md_busy) nb++;
            if (bus.md_done) begin
                nd++;
                done_at = nb;
            end
        end
        tick();
        check("div_busy_cycles", nb, MULDIV ? DIV_N : 0);
        check("div_done_count", nd, MULDIV ? 1 : 0);
        check("div_done_at", done_at, MULDIV ? DIV_N : 0);

        // Reset during busy cycle 10 of a DIV
        wait_quiet();
        drive(1'b1, {6'h00, 20'h0, 6'h1a}, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("mid_rst");
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.md_done) nd++;
        end
        tick();
        check("mid_rst_no_done", nd, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            tick();
        end
        wait_quiet();
        @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
